uart_rx_ctrl: RTL and testbench

- Frame-level controller for the UART receiver back end.
- Detects the start condition on RX_IN and generates the per-bit edge counter and sample enable for the 3-sample majority-vote data sampler.
- Consumes the sampler's bit and done strobe, deserializes the data bits LSB first, and checks start, parity and stop.
- Delivers a validated parallel word with a one-cycle valid pulse.

---
 rtl/uart_rx_ctrl.sv | 237 +++++++++++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: frame-level control for the UART receive path.
// Finds the start bit, runs the oversampling edge counter that paces the
// external majority-vote sampler, shifts in data LSB first, checks parity
// and stop, and reports each frame with one-cycle result pulses.
//
// Optional feature macro: UART_RX_ERR_CNT_EN adds an 8-bit saturating
// err_count output that counts frames ending in a parity or stop error.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | line idle, waiting for RX_IN low; counters held at 0
// START  | start bit; a sampled 1 is a false start and aborts the frame
// DATA   | DATA_WIDTH data bits, shifted in LSB first
// PARITY | parity bit (only when PAR_EN was set at frame start)
// STOP   | stop bit; leaves on the sample, not the wrap, so a start bit
//        | that follows immediately is still seen from IDLE
module uart_rx_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [PRESCALE_W-1:0] Prescale,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  sampled_bit,
  input  logic                  sample_done,
  output logic                  dat_samp_en,
  output logic [PRESCALE_W-1:0] edge_cnt,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err,
`ifdef UART_RX_ERR_CNT_EN
  output logic [7:0]            err_count,
`endif
  output logic                  busy
);

  localparam int BIT_CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BIT_CNT_W-1:0]  LAST_BIT  = BIT_CNT_W'(DATA_WIDTH - 1);
  localparam logic [BIT_CNT_W-1:0]  BIT_ONE   = BIT_CNT_W'(1);
  localparam logic [PRESCALE_W-1:0] EDGE_ONE  = PRESCALE_W'(1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t                  state_q, state_d;
  logic [PRESCALE_W-1:0]   edge_cnt_q, edge_cnt_d;
  logic [BIT_CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0]   shift_q, shift_d;
  logic [PRESCALE_W-1:0]   prescale_q, prescale_d;
  logic                    par_en_q, par_en_d;
  logic                    par_typ_q, par_typ_d;
  logic                    par_fail_q, par_fail_d;
  logic [DATA_WIDTH-1:0]   p_data_q, p_data_d;
  logic                    data_valid_q, data_valid_d;
  logic                    par_err_q, par_err_d;
  logic                    stp_err_q, stp_err_d;

  // FSM strobes consumed by the datapath blocks
  logic latch_cfg;
  logic shift_en;
  logic par_chk;
  logic frame_end;

  logic edge_wrap;
  logic par_fail_eff;
  logic stp_fail;

  assign edge_wrap    = (edge_cnt_q == (prescale_q - EDGE_ONE));
  assign par_fail_eff = par_en_q & par_fail_q;
  assign stp_fail     = ~sampled_bit;

  // Next-state logic and per-state strobes
  always_comb begin
    state_d   = state_q;
    latch_cfg = 1'b0;
    shift_en  = 1'b0;
    par_chk   = 1'b0;
    frame_end = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!RX_IN) begin
          state_d   = S_START;
          latch_cfg = 1'b1;
        end
      end
      S_START: begin
        if (sample_done && sampled_bit) begin
          state_d = S_IDLE;
        end else if (edge_wrap) begin
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        shift_en = sample_done;
        if (edge_wrap && (bit_cnt_q == LAST_BIT)) begin
          state_d = par_en_q ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        par_chk = sample_done;
        if (edge_wrap) begin
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (sample_done) begin
          frame_end = 1'b1;
          state_d   = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Edge counter runs only while a frame is active and restarts at 0 on entry
  always_comb begin
    edge_cnt_d = '0;
    if ((state_q != S_IDLE) && (state_d != S_IDLE)) begin
      edge_cnt_d = edge_wrap ? '0 : (edge_cnt_q + EDGE_ONE);
    end
  end

  // Data bit index advances on each bit wrap inside DATA
  always_comb begin
    bit_cnt_d = '0;
    if (state_q == S_DATA) begin
      bit_cnt_d = bit_cnt_q;
      if (edge_wrap) begin
        bit_cnt_d = (bit_cnt_q == LAST_BIT) ? '0 : (bit_cnt_q + BIT_ONE);
      end
    end
  end

  // Frame configuration snapshot and receive shift register
  always_comb begin
    prescale_d = prescale_q;
    par_en_d   = par_en_q;
    par_typ_d  = par_typ_q;
    shift_d    = shift_q;
    par_fail_d = par_fail_q;
    if (latch_cfg) begin
      prescale_d = Prescale;
      par_en_d   = PAR_EN;
      par_typ_d  = PAR_TYP;
      shift_d    = '0;
      par_fail_d = 1'b0;
    end
    if (shift_en) begin
      shift_d = {sampled_bit, shift_q[DATA_WIDTH-1:1]};
    end
    if (par_chk) begin
      par_fail_d = ((^shift_q) ^ par_typ_q) != sampled_bit;
    end
  end

  // Frame-end result pulses; P_DATA only moves on a clean frame
  always_comb begin
    data_valid_d = frame_end & ~par_fail_eff & ~stp_fail;
    par_err_d    = frame_end & par_fail_eff;
    stp_err_d    = frame_end & stp_fail;
    p_data_d     = data_valid_d ? shift_q : p_data_q;
  end

  // State and datapath registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= S_IDLE;
      edge_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      prescale_q   <= '0;
      par_en_q     <= 1'b0;
      par_typ_q    <= 1'b0;
      par_fail_q   <= 1'b0;
      p_data_q     <= '0;
      data_valid_q <= 1'b0;
      par_err_q    <= 1'b0;
      stp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      edge_cnt_q   <= edge_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      prescale_q   <= prescale_d;
      par_en_q     <= par_en_d;
      par_typ_q    <= par_typ_d;
      par_fail_q   <= par_fail_d;
      p_data_q     <= p_data_d;
      data_valid_q <= data_valid_d;
      par_err_q    <= par_err_d;
      stp_err_q    <= stp_err_d;
    end
  end

`ifdef UART_RX_ERR_CNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  // Saturating count of frames that ended with a parity or stop error
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (frame_end && (par_fail_eff || stp_fail) && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  // Error counter register, cleared only by reset
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_count = err_cnt_q;
`endif

  assign busy        = (state_q != S_IDLE);
  assign dat_samp_en = (state_q != S_IDLE);
  assign edge_cnt    = edge_cnt_q;
  assign P_DATA      = p_data_q;
  assign data_valid  = data_valid_q;
  assign par_err     = par_err_q;
  assign stp_err     = stp_err_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: drives serial frames, models the external
// sampler, and checks result pulses against a queue of expected outcomes.
module tb_uart_rx_ctrl;
  localparam int DW = 8;
  localparam int PW = 6;

  logic          CLK = 1'b0;
  logic          RST;
  logic          RX_IN;
  logic [PW-1:0] Prescale;
  logic          PAR_EN;
  logic          PAR_TYP;
  logic          sampled_bit;
  logic          sample_done;
  logic          dat_samp_en;
  logic [PW-1:0] edge_cnt;
  logic [DW-1:0] P_DATA;
  logic          data_valid;
  logic          par_err;
  logic          stp_err;
  logic          busy;
`ifdef UART_RX_ERR_CNT_EN
  logic [7:0]    err_count;
`endif

  uart_rx_ctrl #(.DATA_WIDTH(DW), .PRESCALE_W(PW)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .RX_IN       (RX_IN),
    .Prescale    (Prescale),
    .PAR_EN      (PAR_EN),
    .PAR_TYP     (PAR_TYP),
    .sampled_bit (sampled_bit),
    .sample_done (sample_done),
    .dat_samp_en (dat_samp_en),
    .edge_cnt    (edge_cnt),
    .P_DATA      (P_DATA),
    .data_valid  (data_valid),
    .par_err     (par_err),
    .stp_err     (stp_err),
`ifdef UART_RX_ERR_CNT_EN
    .err_count   (err_count),
`endif
    .busy        (busy)
  );

  always #5 CLK = ~CLK;

  int cyc     = 0;
  int samp_p  = 8;
  int checks  = 0;
  int errors  = 0;
  int exp_err = 0;

  localparam logic [2:0] K_VALID = 3'b100;
  localparam logic [2:0] K_PAR   = 3'b010;
  localparam logic [2:0] K_STP   = 3'b001;

  typedef struct {
    logic [2:0] kind;
    logic [7:0] data;
    int         lat;
    int         start_cyc;
  } exp_t;

  exp_t exp_q[$];

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Sampler model: one strobe per bit at edge P/2+2, reporting the line level
  initial begin
    sample_done = 1'b0;
    sampled_bit = 1'b1;
    forever begin
      @(negedge CLK);
      #1;
      sample_done = dat_samp_en && (int'(edge_cnt) == samp_p / 2 + 2);
      sampled_bit = RX_IN;
    end
  end

  // Monitor: every result pulse is matched against the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (data_valid || par_err || stp_err) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pulse", {29'd0, data_valid, par_err, stp_err}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("pulse_kind", {29'd0, data_valid, par_err, stp_err}, {29'd0, e.kind});
          check("p_data", {24'd0, P_DATA}, {24'd0, e.data});
          check("latency", cyc - e.start_cyc, e.lat);
          check("busy_at_pulse", {31'd0, busy}, 32'd0);
`ifdef UART_RX_ERR_CNT_EN
          if (e.kind != K_VALID && exp_err < 255) exp_err++;
          check("err_count", {24'd0, err_count}, exp_err);
`endif
        end
      end
    end
  end

  // Must be entered just after a negedge; returns just after a negedge with
  // the line back to idle high, so a following call starts back-to-back.
  task automatic send_frame(input logic [7:0] data, input int p, input logic pen,
                            input logic ptyp, input logic pbit, input logic stopb,
                            input logic [2:0] kind, input logic [7:0] exp_data, input int lat);
    exp_t e;
    Prescale = PW'(p);
    PAR_EN   = pen;
    PAR_TYP  = ptyp;
    samp_p   = p;
    e.kind      = kind;
    e.data      = exp_data;
    e.lat       = lat;
    e.start_cyc = cyc + 1;
    exp_q.push_back(e);
    RX_IN = 1'b0;
    for (int i = 0; i < 8; i++) begin
      repeat (p) @(negedge CLK);
      RX_IN = data[i];
    end
    if (pen) begin
      repeat (p) @(negedge CLK);
      RX_IN = pbit;
    end
    repeat (p) @(negedge CLK);
    RX_IN = stopb;
    repeat (p) @(negedge CLK);
    RX_IN = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RST      = 1'b1;
    RX_IN    = 1'b1;
    Prescale = PW'(8);
    PAR_EN   = 1'b0;
    PAR_TYP  = 1'b0;
    repeat (3) @(negedge CLK);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_samp_en", {31'd0, dat_samp_en}, 32'd0);
    check("rst_edge_cnt", {26'd0, edge_cnt}, 32'd0);
    check("rst_p_data", {24'd0, P_DATA}, 32'd0);
    check("rst_pulses", {29'd0, data_valid, par_err, stp_err}, 32'd0);
`ifdef UART_RX_ERR_CNT_EN
    check("rst_err_count", {24'd0, err_count}, 32'd0);
`endif
    RST = 1'b0;
    repeat (4) @(negedge CLK);
    check("idle_busy", {31'd0, busy}, 32'd0);
    check("idle_edge_cnt", {26'd0, edge_cnt}, 32'd0);

    // 0xA5, P=8, no parity: (1+8)*8 + 4 + 3 = 79
    send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b0, 1'b1, K_VALID, 8'hA5, 79);
    repeat (10) @(negedge CLK);
    // 0x3C, P=16, even parity, correct bit 0: 10*16 + 8 + 3 = 171
    send_frame(8'h3C, 16, 1'b1, 1'b0, 1'b0, 1'b1, K_VALID, 8'h3C, 171);
    repeat (10) @(negedge CLK);
    // 0x3C with wrong parity bit 1: par_err, P_DATA holds 0x3C
    send_frame(8'h3C, 16, 1'b1, 1'b0, 1'b1, 1'b1, K_PAR, 8'h3C, 171);
    repeat (10) @(negedge CLK);
    // 0x07, P=8, odd parity, correct bit 0: 10*8 + 4 + 3 = 87
    send_frame(8'h07, 8, 1'b1, 1'b1, 1'b0, 1'b1, K_VALID, 8'h07, 87);
    repeat (10) @(negedge CLK);
    // 0x0F, P=8, stop bit 0: stp_err, P_DATA holds 0x07
    send_frame(8'h0F, 8, 1'b0, 1'b0, 1'b0, 1'b0, K_STP, 8'h07, 79);
    repeat (10) @(negedge CLK);

    // Glitch: low for 2 cycles, sample at edge 6 sees 1, IDLE in cycle 7
    Prescale = PW'(8);
    PAR_EN   = 1'b0;
    samp_p   = 8;
    RX_IN    = 1'b0;
    repeat (2) @(negedge CLK);
    RX_IN = 1'b1;
    repeat (5) @(negedge CLK);
    check("glitch_busy_cycle6", {31'd0, busy}, 32'd1);
    check("glitch_samp_en_cycle6", {31'd0, dat_samp_en}, 32'd1);
    check("glitch_edge_cycle6", {26'd0, edge_cnt}, 32'd6);
    @(negedge CLK);
    check("glitch_busy_cycle7", {31'd0, busy}, 32'd0);
    check("glitch_edge_cycle7", {26'd0, edge_cnt}, 32'd0);
    repeat (20) @(negedge CLK);
`ifdef UART_RX_ERR_CNT_EN
    check("glitch_err_count", {24'd0, err_count}, exp_err);
`endif

    // Back-to-back at P=32: 9*32 + 16 + 3 = 307 each; Prescale changes mid-frame
    send_frame(8'h55, 32, 1'b0, 1'b0, 1'b0, 1'b1, K_VALID, 8'h55, 307);
    fork
      send_frame(8'hAA, 32, 1'b0, 1'b0, 1'b0, 1'b1, K_VALID, 8'hAA, 307);
      begin
        repeat (100) @(negedge CLK);
        Prescale = PW'(8);
      end
    join
    repeat (10) @(negedge CLK);

    // Reset during data bit 3, then a clean 0x81 frame
    Prescale = PW'(8);
    PAR_EN   = 1'b0;
    samp_p   = 8;
    RX_IN    = 1'b0;
    for (int i = 0; i < 4; i++) begin
      repeat (8) @(negedge CLK);
      RX_IN = 1'b1;
    end
    repeat (4) @(negedge CLK);
    check("abort_busy_before_rst", {31'd0, busy}, 32'd1);
    RST     = 1'b1;
    exp_err = 0;
    repeat (2) @(negedge CLK);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_p_data", {24'd0, P_DATA}, 32'd0);
    check("abort_edge_cnt", {26'd0, edge_cnt}, 32'd0);
    RST = 1'b0;
    repeat (4) @(negedge CLK);
    send_frame(8'h81, 8, 1'b0, 1'b0, 1'b0, 1'b1, K_VALID, 8'h81, 79);

    for (int i = 0; i < 1000 && exp_q.size() != 0; i++) @(negedge CLK);
    check("pending_expected", exp_q.size(), 32'd0);
    repeat (10) @(negedge CLK);
    check("final_busy", {31'd0, busy}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
